// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: condition codes, NZCV flag indices, ALU command encodings.
package arm_pkg;

  localparam int unsigned NZCV_W = 4;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_e;

  // Data-processing opcodes, shared with the ALU
  typedef enum logic [3:0] {
    CMD_AND = 4'h0, CMD_EOR = 4'h1, CMD_SUB = 4'h2, CMD_RSB = 4'h3,
    CMD_ADD = 4'h4, CMD_ADC = 4'h5, CMD_SBC = 4'h6, CMD_RSC = 4'h7,
    CMD_TST = 4'h8, CMD_TEQ = 4'h9, CMD_CMP = 4'hA, CMD_CMN = 4'hB,
    CMD_ORR = 4'hC, CMD_MOV = 4'hD, CMD_BIC = 4'hE, CMD_MVN = 4'hF
  } exe_cmd_e;

endpackage

// File: rtl/status_cond_unit_cond_eval.sv
// Pure combinational ARM condition-code evaluator over an NZCV vector.
module cond_eval
  import arm_pkg::*;
(
  input  cond_e              cond,
  input  logic [NZCV_W-1:0]  nzcv,
  output logic               pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c && !z;
      LS: pass = !c || z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = !z && (n == v);
      LE: pass = z || (n != v);
      AL: pass = 1'b1;
      NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/status_cond_unit.sv
// Architectural NZCV register, ID-stage condition check, flag-hazard stall and event counters.
// Build option: define FLAG_FWD_EN to forward EXE flags into the condition check instead of stalling.
module status_cond_unit
  import arm_pkg::*;
#(
  parameter int unsigned      CNT_W     = 32,
  parameter logic [NZCV_W-1:0] RST_FLAGS = 4'b0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exe_valid,
  input  logic               exe_s,
  input  logic [NZCV_W-1:0]  alu_status,
  input  logic               id_valid,
  input  logic [3:0]         id_cond,
  input  logic               freeze,
  input  logic               flush,
  output logic [NZCV_W-1:0]  status_q,
  output logic               cin,
  output logic               cond_pass,
  output logic               flag_stall,
  output logic [CNT_W-1:0]   fail_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic              flag_wr;
  logic [NZCV_W-1:0] eff_flags;
  logic              eval_pass;
  logic              fail_inc;
  logic              stall_inc;

  assign flag_wr = exe_valid && exe_s && !flush;

`ifdef FLAG_FWD_EN
  // In-flight flags bypass the register, so no hazard can arise
  assign eff_flags  = flag_wr ? alu_status : status_q;
  assign flag_stall = 1'b0;
`else
  assign eff_flags  = status_q;
  assign flag_stall = !rst && flag_wr && id_valid && (id_cond != AL);
`endif

  cond_eval u_cond_eval (
    .cond (cond_e'(id_cond)),
    .nzcv (eff_flags),
    .pass (eval_pass)
  );

  assign cond_pass = !rst && id_valid && !flag_stall && eval_pass;
  assign cin       = status_q[FLAG_C];

  // A frozen ID instruction is only counted once it is allowed to advance
  assign fail_inc  = id_valid && !flag_stall && !freeze && !flush && !eval_pass;
  assign stall_inc = flag_stall && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q  <= RST_FLAGS;
      fail_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (flag_wr) begin
        status_q <= alu_status;
      end
      if (fail_inc && (fail_cnt != '1)) begin
        fail_cnt <= fail_cnt + CNT_W'(1);
      end
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
